msi_memory_responder: RTL and testbench



---
 rtl/msi_mem_if.sv | 25 ++
 rtl/msi_memory_responder.sv | 113 +++++++++++
 tb/tb_msi_memory_responder.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/msi_mem_if.sv
// Bus-side signal bundle between the snooping MSI bus and the memory responder.
// Handshake: bus_valid qualifies bus_msg for the one cycle it is high and there is no backpressure;
// reply_valid and req_drop are single-cycle pulses, and reply_msg is meaningful only while reply_valid is high.
interface msi_mem_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W+5:0] bus_msg;
  logic              bus_valid;
  logic              abort_mem;
  logic              data_wb;
  logic [DATA_W+5:0] reply_msg;
  logic              reply_valid;
  logic              busy;
  logic              req_drop;

  modport master (
    output bus_msg, bus_valid, abort_mem, data_wb,
    input  reply_msg, reply_valid, busy, req_drop
  );

  modport slave (
    input  bus_msg, bus_valid, abort_mem, data_wb,
    output reply_msg, reply_valid, busy, req_drop
  );
endinterface

// File: rtl/msi_memory_responder.sv
// Memory-side responder for the snooping MSI bus: answers misses after a fixed latency,
// lets an M-state owner abort the pending reply, and absorbs write-backs into a 16-word store.
module msi_memory_responder #(
  parameter int LATENCY = 3,
  parameter int DATA_W  = 16
) (
  input  logic        clock,
  input  logic        reset,
  msi_mem_if.slave    bus,
  output logic [1:0]  o_dbg_state
);

  localparam int MSG_W = DATA_W + 6;
  localparam logic [3:0] LAT = 4'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_REPLY = 2'd2
  } state_t;

  state_t             r_state, w_state_n;
  logic [3:0]         r_cnt, w_cnt_n;
  logic [3:0]         r_addr, w_addr_n;
  logic [DATA_W-1:0]  r_mem [16];
  logic [MSG_W-1:0]   r_reply_msg, w_reply_msg_n;
  logic               r_reply_valid, w_reply_valid_n;
  logic               r_req_drop, w_req_drop_n;

  logic               w_wr_en;
  logic [3:0]         w_wr_addr;
  logic [DATA_W-1:0]  w_wr_data;

  logic [1:0]         w_type;
  logic [3:0]         w_bus_addr;
  logic [DATA_W-1:0]  w_bus_data;
  logic               w_is_miss;
  logic               w_is_wb;

  assign w_type     = bus.bus_msg[MSG_W-1 -: 2];
  assign w_bus_addr = bus.bus_msg[DATA_W+3 -: 4];
  assign w_bus_data = bus.bus_msg[DATA_W-1:0];
  assign w_is_miss  = bus.bus_valid && (w_type == 2'b01 || w_type == 2'b10);
  assign w_is_wb    = bus.bus_valid && (w_type == 2'b11);

  always_comb begin
    w_state_n       = r_state;
    w_cnt_n         = r_cnt;
    w_addr_n        = r_addr;
    w_reply_msg_n   = r_reply_msg;
    w_reply_valid_n = 1'b0;
    w_req_drop_n    = 1'b0;
    w_wr_en         = w_is_wb;
    w_wr_addr       = w_bus_addr;
    w_wr_data       = w_bus_data;
    case (r_state)
      S_IDLE: begin
        if (w_is_miss) begin
          w_state_n = S_WAIT;
          w_cnt_n   = LAT;
          w_addr_n  = w_bus_addr;
        end
      end
      S_WAIT: begin
        // While aborting, bus_msg carries the owner's data for the pending line, not a new request.
        if (bus.abort_mem) begin
          w_state_n = S_IDLE;
          w_cnt_n   = '0;
          w_wr_en   = bus.data_wb;
          w_wr_addr = r_addr;
        end else begin
          w_req_drop_n = w_is_miss;
          w_cnt_n      = r_cnt - 4'd1;
          if (r_cnt == 4'd1) w_state_n = S_REPLY;
        end
      end
      S_REPLY: begin
        w_req_drop_n    = w_is_miss;
        w_reply_valid_n = 1'b1;
        w_reply_msg_n   = {2'b01, r_addr, r_mem[r_addr]};
        w_state_n       = S_IDLE;
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_addr        <= '0;
      r_reply_msg   <= '0;
      r_reply_valid <= 1'b0;
      r_req_drop    <= 1'b0;
      for (int i = 0; i < 16; i++) r_mem[i] <= '0;
    end else begin
      r_state       <= w_state_n;
      r_cnt         <= w_cnt_n;
      r_addr        <= w_addr_n;
      r_reply_msg   <= w_reply_msg_n;
      r_reply_valid <= w_reply_valid_n;
      r_req_drop    <= w_req_drop_n;
      if (w_wr_en) r_mem[w_wr_addr] <= w_wr_data;
    end
  end

  assign bus.reply_msg   = r_reply_msg;
  assign bus.reply_valid = r_reply_valid;
  assign bus.req_drop    = r_req_drop;
  assign bus.busy        = (r_state == S_WAIT);
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_msi_memory_responder.sv
// Bench for msi_memory_responder: directed scenarios plus random traffic, checked against
// a transaction-level model that tracks each accepted miss by the cycle it was taken.
module tb_msi_memory_responder;

  localparam int L = 3;
  localparam int DW = 16;

  logic       clock;
  logic       reset;
  logic [1:0] dbg_state;

  msi_mem_if #(.DATA_W(DW)) bus_if ();

  msi_memory_responder #(.LATENCY(L), .DATA_W(DW)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus_if),
    .o_dbg_state (dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a memory array plus one pending request stamped with its accept cycle.
  logic [DW-1:0]   m_mem [16];
  logic            m_pend;
  int              m_acc;
  logic [3:0]      m_addr;
  logic [DW+5:0]   m_last;
  int              m_cyc;
  logic            exp_rv, exp_drop, exp_busy;
  logic [DW+5:0]   exp_q[$];

  logic            d_v, d_ab, d_wb, d_rs;
  logic [1:0]      d_ty;
  logic [3:0]      d_a;
  logic [DW-1:0]   d_d;

  task automatic model_step();
    logic miss, wbm, was_pend, aborting;
    int age;
    m_cyc++;
    exp_rv   = 1'b0;
    exp_drop = 1'b0;
    if (d_rs) begin
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
      m_pend = 1'b0;
      m_last = '0;
      exp_q.delete();
    end else begin
      miss     = d_v && (d_ty == 2'b01 || d_ty == 2'b10);
      wbm      = d_v && (d_ty == 2'b11);
      was_pend = m_pend;
      age      = m_cyc - m_acc;
      aborting = m_pend && (age <= L) && d_ab;
      if (m_pend && age == L + 1) begin
        m_last = {2'b01, m_addr, m_mem[m_addr]};
        exp_q.push_back(m_last);
        exp_rv = 1'b1;
        m_pend = 1'b0;
      end
      if (miss && was_pend && !aborting) exp_drop = 1'b1;
      if (aborting) begin
        if (d_wb) m_mem[m_addr] = d_d;
        m_pend = 1'b0;
      end else if (wbm) begin
        m_mem[d_a] = d_d;
      end
      if (miss && !was_pend) begin
        m_pend = 1'b1;
        m_acc  = m_cyc;
        m_addr = d_a;
      end
    end
    exp_busy = m_pend && ((m_cyc - m_acc) < L);
  endtask

  task automatic step(input logic v, input logic [1:0] ty, input logic [3:0] a,
                      input logic [DW-1:0] d, input logic ab, input logic wb, input logic rs);
    d_v = v; d_ty = ty; d_a = a; d_d = d; d_ab = ab; d_wb = wb; d_rs = rs;
    bus_if.bus_valid = v;
    bus_if.bus_msg   = {ty, a, d};
    bus_if.abort_mem = ab;
    bus_if.data_wb   = wb;
    reset            = rs;
    @(posedge clock);
    model_step();
    #1;
    check_eq("reply_valid", 32'(bus_if.reply_valid), 32'(exp_rv));
    if (exp_rv) check_eq("reply_msg", 32'(bus_if.reply_msg), 32'(exp_q.pop_front()));
    check_eq("reply_hold", 32'(bus_if.reply_msg), 32'(m_last));
    check_eq("busy", 32'(bus_if.busy), 32'(exp_busy));
    check_eq("req_drop", 32'(bus_if.req_drop), 32'(exp_drop));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 4'h0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic miss(input logic [3:0] a);
    step(1'b1, 2'b01, a, 16'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wback(input logic [3:0] a, input logic [DW-1:0] d);
    step(1'b1, 2'b11, a, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 2'b00, 4'h0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 2'b00, 4'h0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    m_cyc = 0; m_acc = 0; m_pend = 1'b0; m_addr = '0; m_last = '0;
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    reset = 1'b1;
    bus_if.bus_valid = 1'b0; bus_if.bus_msg = '0;
    bus_if.abort_mem = 1'b0; bus_if.data_wb = 1'b0;

    // Reset state
    do_reset();
    check_eq("rst_state", 32'(dbg_state), 32'd0);
    check_eq("rst_msg", 32'(bus_if.reply_msg), 32'd0);

    // Write-back then read: busy three cycles, reply one edge later
    wback(4'h4, 16'hBEEF);
    miss(4'h4);
    check_eq("tp1_busy0", 32'(bus_if.busy), 32'd1);
    idle(2);
    check_eq("tp1_busy2", 32'(bus_if.busy), 32'd1);
    idle(1);
    check_eq("tp1_busy_end", 32'(bus_if.busy), 32'd0);
    check_eq("tp1_not_yet", 32'(bus_if.reply_valid), 32'd0);
    idle(1);
    check_eq("tp1_valid", 32'(bus_if.reply_valid), 32'd1);
    check_eq("tp1_msg", 32'(bus_if.reply_msg), 32'h14BEEF);
    idle(1);
    check_eq("tp1_pulse", 32'(bus_if.reply_valid), 32'd0);

    // Miss while waiting is dropped, single reply for addr 7
    do_reset();
    miss(4'h7);
    idle(1);
    miss(4'h5);
    check_eq("tp2_drop", 32'(bus_if.req_drop), 32'd1);
    idle(1);
    check_eq("tp2_drop_pulse", 32'(bus_if.req_drop), 32'd0);
    idle(1);
    check_eq("tp2_msg", 32'(bus_if.reply_msg), 32'h170000);
    idle(6);

    // Abort with owner write-back lands on the latched address
    step(1'b1, 2'b10, 4'h2, 16'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b11, 4'hF, 16'h1234, 1'b1, 1'b1, 1'b0);
    check_eq("tp3_busy", 32'(bus_if.busy), 32'd0);
    idle(5);
    miss(4'h2);
    idle(4);
    check_eq("tp3_msg", 32'(bus_if.reply_msg), 32'h121234);
    idle(1);

    // Abort on the expiry cycle wins; same-address write-back during WAIT reaches the reply
    miss(4'h9);
    idle(2);
    step(1'b0, 2'b00, 4'h0, '0, 1'b1, 1'b0, 1'b0);
    idle(1);
    check_eq("tp4_no_reply", 32'(bus_if.reply_valid), 32'd0);
    idle(2);
    miss(4'h9);
    wback(4'h9, 16'h00AA);
    idle(3);
    check_eq("tp4_msg", 32'(bus_if.reply_msg), 32'h1900AA);
    idle(1);

    // Reset during WAIT clears memory and kills the reply
    wback(4'h3, 16'h5555);
    miss(4'h3);
    idle(1);
    step(1'b0, 2'b00, 4'h0, '0, 1'b0, 1'b0, 1'b1);
    check_eq("tp5_busy", 32'(bus_if.busy), 32'd0);
    idle(5);
    miss(4'h3);
    idle(4);
    check_eq("tp5_msg", 32'(bus_if.reply_msg), 32'h130000);
    idle(1);

    // Spacing LATENCY+2 accepted, LATENCY+1 dropped
    miss(4'h1);
    idle(L + 1);
    miss(4'h2);
    check_eq("tp6_accept", 32'(bus_if.req_drop), 32'd0);
    check_eq("tp6_busy", 32'(bus_if.busy), 32'd1);
    idle(L + 1);
    check_eq("tp6_msg2", 32'(bus_if.reply_msg), 32'h120000);
    idle(1);
    miss(4'h1);
    idle(L);
    miss(4'h2);
    check_eq("tp6_drop", 32'(bus_if.req_drop), 32'd1);
    idle(3);

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      logic v, ab, wb, rs;
      logic [1:0] ty;
      rs = ($urandom_range(0, 199) == 0);
      ab = ($urandom_range(0, 5) == 0);
      wb = ab ? 1'($urandom_range(0, 1)) : 1'b0;
      v  = ab ? wb : 1'($urandom_range(0, 1));
      ty = ab ? 2'b11 : 2'($urandom_range(0, 3));
      step(v, ty, 4'($urandom_range(0, 7)), 16'($urandom), ab, wb, rs);
    end
    idle(L + 3);
    check_eq("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
